ram_arbiter: RTL

- Shares the single-port word RAM between two requesters:
  - port 0: CPU load/store path.
  - port 1: debug/loader path, used for program/data preload and memory inspection.
- Sits between the requesters and the `ram` instance, replacing the CPU's direct RAM connection.
- Arbitration is round-robin with per-port bus lock for atomic read-modify-write sequences.
- A lock watchdog forces release and flags an error.

---
 rtl/ram_arbiter_pkg.sv | 29 ++
 rtl/ram_arbiter_watchdog.sv | 35 +++
 rtl/ram_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared types and constants for the two-port RAM arbiter.
package ram_arbiter_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int WD_W   = 8;
  localparam int DEFAULT_LOCK_TIMEOUT = 16;

  typedef logic [ADDR_W-1:0] RamAddress;
  typedef logic [DATA_W-1:0] Word;

  typedef enum logic [1:0] {
    ARB_RR,
    ARB_LOCK0,
    ARB_LOCK1
  } ArbState;

  typedef struct packed {
    logic      write;
    logic      lock;
    RamAddress addr;
    Word       wdata;
  } ArbRequest;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ram_arbiter_watchdog.sv
// arb_lock_watchdog: counts consecutive locked cycles and
// flags expiry when a lock has been held for TIMEOUT cycles.
module arb_lock_watchdog
  import ram_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_LOCK_TIMEOUT
)(
  input  logic clk,
  input  logic reset,
  input  logic locked_i,
  input  logic keep_i,
  output logic expire_o
);

  localparam logic [WD_W-1:0] LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] cnt_q, cnt_d;

  assign expire_o = locked_i && (cnt_q == LAST);

  // count only while the lock survives into the next cycle
  always_comb begin
    cnt_d = '0;
    if (locked_i && keep_i)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin sharing of one word RAM between CPU and debug
// ports, with bus lock and lock watchdog. ARB_STATS_EN adds grant counters.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int NPORTS       = 2,
  parameter int LOCK_TIMEOUT = DEFAULT_LOCK_TIMEOUT
)(
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NPORTS-1:0]             req_valid,
  input  logic [NPORTS-1:0]             req_write,
  input  logic [NPORTS-1:0]             req_lock,
  input  logic [NPORTS-1:0][ADDR_W-1:0] req_addr,
  input  logic [NPORTS-1:0][DATA_W-1:0] req_wdata,
  output logic [NPORTS-1:0]             req_ready,
  output logic [NPORTS-1:0]             resp_valid,
  output logic [DATA_W-1:0]             resp_data,
  output logic [ADDR_W-1:0]             ram_address,
  output logic                          ram_write_enable,
  output logic [DATA_W-1:0]             ram_write_data,
  input  logic [DATA_W-1:0]             ram_data,
  output logic                          lock_error
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]                   stat_grants0,
  output logic [31:0]                   stat_grants1,
  output logic [31:0]                   stat_conflicts
`endif
);

  ArbState          state_q, state_d;
  logic             last_q, last_d;
  logic [1:0]       resp_valid_q, resp_valid_d;
  Word              resp_data_q, resp_data_d;
  logic             gnt_any, gnt_sel;
  logic             expire, rd_acc;
  ArbRequest [1:0]  req;
  ArbRequest        cur;

  always_comb begin
    for (int p = 0; p < 2; p++)
      req[p] = {req_write[p], req_lock[p], req_addr[p], req_wdata[p]};
  end

  // reset also masks the grant so ready and RAM strobes drop at once
  always_comb begin
    gnt_any = 1'b0;
    gnt_sel = 1'b0;
    unique case (state_q)
      ARB_RR: begin
        gnt_any = |req_valid;
        gnt_sel = (&req_valid) ? ~last_q : ~req_valid[0];
      end
      ARB_LOCK0: begin
        gnt_any = req_valid[0];
        gnt_sel = 1'b0;
      end
      ARB_LOCK1: begin
        gnt_any = req_valid[1];
        gnt_sel = 1'b1;
      end
      default: ;
    endcase
    if (reset)
      gnt_any = 1'b0;
  end

  assign cur    = req[gnt_sel];
  assign rd_acc = gnt_any && !cur.write;

  assign req_ready        = gnt_any ? (gnt_sel ? 2'b10 : 2'b01) : 2'b00;
  assign ram_address      = gnt_any ? cur.addr : '0;
  assign ram_write_enable = gnt_any && cur.write;
  assign ram_write_data   = gnt_any ? cur.wdata : '0;
  assign resp_valid       = resp_valid_q;
  assign resp_data        = resp_data_q;
  assign lock_error       = expire;

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    resp_valid_d = rd_acc ? req_ready : 2'b00;
    resp_data_d  = rd_acc ? ram_data : resp_data_q;
    if (gnt_any) begin
      last_d = gnt_sel;
      if (state_q == ARB_RR) begin
        if (cur.lock)
          state_d = gnt_sel ? ARB_LOCK1 : ARB_LOCK0;
      end else if (!cur.lock) begin
        state_d = ARB_RR;
      end
    end
    // forced release hands the next conflict to the other port
    if (expire) begin
      state_d = ARB_RR;
      last_d  = (state_q == ARB_LOCK1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ARB_RR;
      last_q       <= 1'b1;
      resp_valid_q <= 2'b00;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  arb_lock_watchdog #(
    .TIMEOUT (LOCK_TIMEOUT)
  ) u_wd (
    .clk      (clk),
    .reset    (reset),
    .locked_i (state_q != ARB_RR),
    .keep_i   (state_d != ARB_RR),
    .expire_o (expire)
  );

`ifdef ARB_STATS_EN
  logic [31:0] grants0_q, grants1_q, conflicts_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grants0_q   <= '0;
      grants1_q   <= '0;
      conflicts_q <= '0;
    end else begin
      if (req_ready[0])
        grants0_q <= sat_inc(grants0_q);
      if (req_ready[1])
        grants1_q <= sat_inc(grants1_q);
      if (|(req_valid & ~req_ready))
        conflicts_q <= sat_inc(conflicts_q);
    end
  end

  assign stat_grants0   = grants0_q;
  assign stat_grants1   = grants1_q;
  assign stat_conflicts = conflicts_q;

  task automatic dump();
    $display("ram_arbiter stats: grants0=%0d grants1=%0d conflicts=%0d",
             grants0_q, grants1_q, conflicts_q);
  endtask
`endif

`ifndef SUPRESS_ERRORS
  logic [1:0]      stall_q;
  ArbRequest [1:0] held_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      held_q  <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (stall_q[p] && req_valid[p])
          assert (held_q[p].write == req[p].write &&
                  held_q[p].addr  == req[p].addr &&
                  held_q[p].wdata == req[p].wdata)
          else $error("ram_arbiter: port %0d request changed while stalled", p);
      end
      stall_q <= req_valid & ~req_ready;
      held_q  <= req;
    end
  end
`endif

endmodule
